// File: rtl/pipelined_multiplier_param.sv
// Pipelined full-width multiplier with signed/unsigned mode, sideband tag and valid/ready flow control.
// Stage 0 captures operands, stage 1 multiplies, and the remaining stages are retiming delays.
module pipelined_multiplier_param #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int LATENCY   = 5,
    parameter int TAG_WIDTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [A_WIDTH-1:0]           A,
    input  logic [B_WIDTH-1:0]           B,
    input  logic                         SIGNED_MODE,
    input  logic [TAG_WIDTH-1:0]         TAG_IN,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [A_WIDTH+B_WIDTH-1:0]   MULT,
    output logic [TAG_WIDTH-1:0]         TAG_OUT,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic                         BUSY
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int LAST    = LATENCY - 1;

    logic [LATENCY-1:0]   valid_q, valid_d;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic                 mode_q, mode_d;
    logic [TAG_WIDTH-1:0] tag_q [LATENCY];
    logic [TAG_WIDTH-1:0] tag_d [LATENCY];
    logic [P_WIDTH-1:0]   prod_q [1:LAST];
    logic [P_WIDTH-1:0]   prod_d [1:LAST];

    logic                 adv;
    logic                 accept;
    logic [P_WIDTH-1:0]   a_ext;
    logic [P_WIDTH-1:0]   b_ext;
    logic [P_WIDTH-1:0]   prod_full;

    assign adv       = !valid_q[LAST] | OUT_READY;
    assign IN_READY  = adv & !RST;
    assign accept    = IN_VALID & IN_READY;

    assign OUT_VALID = valid_q[LAST];
    assign MULT      = prod_q[LAST];
    assign TAG_OUT   = tag_q[LAST];
    assign BUSY      = |valid_q;

    // Modular full-width product is exact for both modes once operands are extended to P_WIDTH.
    always_comb begin
        a_ext     = {{B_WIDTH{a_q[A_WIDTH-1] & mode_q}}, a_q};
        b_ext     = {{A_WIDTH{b_q[B_WIDTH-1] & mode_q}}, b_q};
        prod_full = a_ext * b_ext;
    end

    // Data registers only load behind a valid beat, so bubbles never overwrite the last result.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        tag_d   = tag_q;
        prod_d  = prod_q;
        if (adv) begin
            valid_d[0] = accept;
            if (accept) begin
                a_d      = A;
                b_d      = B;
                mode_d   = SIGNED_MODE;
                tag_d[0] = TAG_IN;
            end
            valid_d[1] = valid_q[0];
            if (valid_q[0]) begin
                prod_d[1] = prod_full;
                tag_d[1]  = tag_q[0];
            end
            for (int i = 2; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    prod_d[i] = prod_q[i-1];
                    tag_d[i]  = tag_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q      <= '0;
            prod_q[LAST] <= '0;
            tag_q[LAST]  <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_pipelined_multiplier_param.sv
// Directed bench for pipelined_multiplier_param: default build plus an 8x12, latency-2 build.
// Expected products come from hand-computed constants and a small reference function.
module tb_pipelined_multiplier_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] a, b;
    logic        sm;
    logic [3:0]  tag_in, tag_out;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [35:0] mult;

    logic [7:0]  a2;
    logic [11:0] b2;
    logic        sm2, iv2, ir2, ov2, or2, busy2;
    logic [3:0]  tag2_in, tag2_out;
    logic [19:0] mult2;

    int n_checks = 0;
    int n_errors = 0;
    int n_out, ov_run, ov_max, cnt, sent, stall_cnt;
    logic [35:0] held_m;
    logic [3:0]  held_t;
    logic [35:0] exp_mult [$];
    logic [3:0]  exp_tag  [$];

    always #5 clk = ~clk;

    pipelined_multiplier_param dut (
        .CLK(clk), .RST(rst), .A(a), .B(b), .SIGNED_MODE(sm), .TAG_IN(tag_in),
        .IN_VALID(in_valid), .IN_READY(in_ready), .MULT(mult), .TAG_OUT(tag_out),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .BUSY(busy)
    );

    pipelined_multiplier_param #(.A_WIDTH(8), .B_WIDTH(12), .LATENCY(2), .TAG_WIDTH(4)) dut2 (
        .CLK(clk), .RST(rst), .A(a2), .B(b2), .SIGNED_MODE(sm2), .TAG_IN(tag2_in),
        .IN_VALID(iv2), .IN_READY(ir2), .MULT(mult2), .TAG_OUT(tag2_out),
        .OUT_VALID(ov2), .OUT_READY(or2), .BUSY(busy2)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [35:0] ref1(input logic [17:0] x, input logic [17:0] y, input logic m);
        logic signed [35:0] s;
        logic [35:0] u;
        s = 36'($signed(x)) * 36'($signed(y));
        u = 36'(x) * 36'(y);
        return m ? s : u;
    endfunction

    function automatic logic [19:0] ref2(input logic [7:0] x, input logic [11:0] y, input logic m);
        logic signed [19:0] s;
        logic [19:0] u;
        s = 20'($signed(x)) * 20'($signed(y));
        u = 20'(x) * 20'(y);
        return m ? s : u;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of streaming on the default build, scoreboarding accepts and handoffs.
    task automatic step1();
        logic acc, hand;
        logic [35:0] m;
        logic [3:0] t;
        acc  = in_valid && in_ready;
        hand = out_valid && out_ready;
        m    = mult;
        t    = tag_out;
        if (acc) begin
            exp_mult.push_back(ref1(a, b, sm));
            exp_tag.push_back(tag_in);
        end
        if (hand) begin
            n_out++;
            ov_run++;
            if (ov_run > ov_max) ov_max = ov_run;
            check("out_has_pending_beat", 64'(exp_mult.size() != 0), 64'd1);
            if (exp_mult.size() != 0) begin
                check("stream_mult", 64'(m), 64'(exp_mult.pop_front()));
                check("stream_tag", 64'(t), 64'(exp_tag.pop_front()));
            end
        end else begin
            ov_run = 0;
        end
        tick();
    endtask

    task automatic single1(input logic [17:0] x, input logic [17:0] y, input logic m,
                           input logic [3:0] t, input logic [35:0] exp_m, input string name);
        a = x; b = y; sm = m; tag_in = t; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check({name, "_latency"}, 64'(cnt), 64'd5);
        check({name, "_mult"}, 64'(mult), 64'(exp_m));
        check({name, "_tag"}, 64'(tag_out), 64'(t));
        tick();
    endtask

    task automatic single2(input logic [7:0] x, input logic [11:0] y, input logic m,
                           input logic [3:0] t, input logic [19:0] exp_m, input string name);
        a2 = x; b2 = y; sm2 = m; tag2_in = t; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        cnt = 1;
        while (!ov2 && cnt < 20) begin
            tick();
            cnt++;
        end
        check({name, "_latency"}, 64'(cnt), 64'd2);
        check({name, "_mult"}, 64'(mult2), 64'(exp_m));
        check({name, "_tag"}, 64'(tag2_out), 64'(t));
        tick();
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; sm = 1'b0; tag_in = '0; in_valid = 1'b0; out_ready = 1'b1;
        a2 = '0; b2 = '0; sm2 = 1'b0; tag2_in = '0; iv2 = 1'b0; or2 = 1'b1;
        n_out = 0; ov_run = 0; ov_max = 0; cnt = 0; sent = 0; stall_cnt = 0;
        held_m = '0; held_t = '0;

        // Reset state
        repeat (3) tick();
        in_valid = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mult", 64'(mult), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready2", 64'(ir2), 64'd0);
        tick();
        check("rst_no_accept_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Max unsigned operands, exact edge timing
        a = 18'h3FFFF; b = 18'h3FFFF; sm = 1'b0; tag_in = 4'h3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_in_flight", 64'(busy), 64'd1);
        repeat (3) tick();
        check("no_early_out", 64'(out_valid), 64'd0);
        tick();
        check("max_out_valid", 64'(out_valid), 64'd1);
        check("max_mult", 64'(mult), 64'hFFFF80001);
        check("max_tag", 64'(tag_out), 64'h3);
        tick();
        check("max_out_gone", 64'(out_valid), 64'd0);
        check("max_busy_clear", 64'(busy), 64'd0);

        // Signed versus unsigned
        single1(18'h3FFFF, 18'h00002, 1'b1, 4'h5, 36'hFFFFFFFFE, "neg1x2_signed");
        single1(18'h3FFFF, 18'h00002, 1'b0, 4'h6, 36'h00007FFFE, "neg1x2_unsigned");
        single1(18'h3FFFF, 18'h3FFFF, 1'b1, 4'h7, 36'h000000001, "neg1xneg1_signed");
        single1(18'h20000, 18'h20000, 1'b1, 4'h8, 36'h400000000, "minxmin_signed");

        // 20 beats back to back
        n_out = 0; ov_run = 0; ov_max = 0;
        for (int i = 0; i < 20; i++) begin
            a = 18'(i); b = 18'(i + 1); sm = 1'b0; tag_in = 4'(i); in_valid = 1'b1;
            step1();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_mult.size() != 0; i++) step1();
        check("b2b_count", 64'(n_out), 64'd20);
        check("b2b_consecutive", 64'(ov_max), 64'd20);
        check("b2b_drained", 64'(exp_mult.size()), 64'd0);

        // Output stall with input pressure
        n_out = 0; sent = 0; stall_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (sent < 6);
            a = 18'(sent * 1000 + 7); b = 18'(18'h3FFF0 - sent); sm = sent[0]; tag_in = 4'(sent + 8);
            out_ready = !(out_valid && stall_cnt < 3);
            #1;
            if (!out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                if (stall_cnt == 0) begin
                    held_m = mult;
                    held_t = tag_out;
                end else begin
                    check("stall_mult_stable", 64'(mult), 64'(held_m));
                    check("stall_tag_stable", 64'(tag_out), 64'(held_t));
                    check("stall_valid_stable", 64'(out_valid), 64'd1);
                end
                stall_cnt++;
            end
            if (in_valid && in_ready) sent++;
            step1();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall_stalled", 64'(stall_cnt), 64'd3);
        check("stall_count", 64'(n_out), 64'd6);
        check("stall_drained", 64'(exp_mult.size()), 64'd0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            a = 18'(i + 50); b = 18'(i + 60); sm = 1'b0; tag_in = 4'(i + 1); in_valid = 1'b1;
            step1();
        end
        in_valid = 1'b0;
        check("flight_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        exp_mult.delete();
        exp_tag.delete();
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_mult", 64'(mult), 64'd0);
        check("midrst_tag", 64'(tag_out), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check("midrst_no_ghost", 64'(out_valid), 64'd0);
            step1();
        end
        check("midrst_mult_after", 64'(mult), 64'd0);

        // Narrow build, latency 2
        single2(8'h80, 12'h800, 1'b1, 4'h1, 20'h40000, "w_minxmin_s");
        single2(8'h80, 12'h800, 1'b0, 4'h2, 20'h40000, "w_minxmin_u");
        single2(8'hFF, 12'h001, 1'b1, 4'h3, 20'hFFFFF, "w_neg1x1_s");
        single2(8'hFF, 12'h001, 1'b0, 4'h4, 20'h000FF, "w_neg1x1_u");
        single2(8'h7F, 12'h7FF, 1'b1, 4'h5, 20'h3F781, "w_maxpos_s");
        single2(8'h80, 12'h7FF, 1'b1, 4'h6, 20'hC0080, "w_mixed_s");
        single2(8'h80, 12'h7FF, 1'b0, 4'h7, 20'h3FF80, "w_mixed_u");
        for (int k = 0; k < 10; k++) begin
            logic [7:0]  rx;
            logic [11:0] ry;
            logic        rm;
            rx = 8'($urandom);
            ry = 12'($urandom);
            rm = 1'($urandom_range(0, 1));
            single2(rx, ry, rm, 4'(k), ref2(rx, ry, rm), "w_random");
        end
        check("w_busy_idle", 64'(busy2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
